// File: rtl/rgb_pwm_driver.sv
// RGB565 to three-channel PWM LED driver with period-aligned shadow duties and a frame strobe.
// Define RGB_PWM_ACTIVE_LOW_EN for active-low (common-anode) LED pins; default is active-high.
module rgb_pwm_driver #(
    parameter int unsigned PRESCALE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] rgb,
    input  logic        en,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b,
    output logic        frame
);

    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

`ifdef RGB_PWM_ACTIVE_LOW_EN
    localparam logic LedOff = 1'b1;
`else
    localparam logic LedOff = 1'b0;
`endif

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [PreW-1:0] pre_q, pre_d;
    logic [5:0]      step_q, step_d;
    logic [5:0]      sh_r_q, sh_r_d;
    logic [5:0]      sh_g_q, sh_g_d;
    logic [5:0]      sh_b_q, sh_b_d;
    logic            led_r_q, led_r_d;
    logic            led_g_q, led_g_d;
    logic            led_b_q, led_b_d;
    logic            frame_q, frame_d;

    logic [5:0] duty_r, duty_g, duty_b;
    logic       tick;
    logic       wrap;

    // 5-bit channels replicate their MSB so full scale maps to 63.
    assign duty_r = {rgb[15:11], rgb[15]};
    assign duty_g = rgb[10:5];
    assign duty_b = {rgb[4:0], rgb[4]};

    assign tick = (pre_q == PreMax);
    assign wrap = tick && (step_q == 6'd63);

    always_comb begin
        state_d = en ? StRun : StIdle;
        pre_d   = pre_q;
        step_d  = step_q;
        sh_r_d  = sh_r_q;
        sh_g_d  = sh_g_q;
        sh_b_d  = sh_b_q;
        led_r_d = LedOff;
        led_g_d = LedOff;
        led_b_d = LedOff;
        frame_d = 1'b0;

        if (!en) begin
            // Idle tracks rgb continuously so the first run period uses the latest colour.
            pre_d  = '0;
            step_d = '0;
            sh_r_d = duty_r;
            sh_g_d = duty_g;
            sh_b_d = duty_b;
        end else begin
            if (tick) begin
                pre_d  = '0;
                step_d = step_q + 6'd1;
            end else begin
                pre_d  = pre_q + 1'b1;
            end
            if (wrap) begin
                sh_r_d = duty_r;
                sh_g_d = duty_g;
                sh_b_d = duty_b;
            end
            led_r_d = LedOff ^ (step_q < sh_r_q);
            led_g_d = LedOff ^ (step_q < sh_g_q);
            led_b_d = LedOff ^ (step_q < sh_b_q);
            frame_d = wrap || (state_q == StIdle);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pre_q   <= '0;
            step_q  <= '0;
            sh_r_q  <= '0;
            sh_g_q  <= '0;
            sh_b_q  <= '0;
            led_r_q <= LedOff;
            led_g_q <= LedOff;
            led_b_q <= LedOff;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            step_q  <= step_d;
            sh_r_q  <= sh_r_d;
            sh_g_q  <= sh_g_d;
            sh_b_q  <= sh_b_d;
            led_r_q <= led_r_d;
            led_g_q <= led_g_d;
            led_b_q <= led_b_d;
            frame_q <= frame_d;
        end
    end

    assign led_r = led_r_q;
    assign led_g = led_g_q;
    assign led_b = led_b_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Self-checking bench for rgb_pwm_driver: cycle-count reference model plus directed and random runs.
module tb_rgb_pwm_driver;

    localparam int P   = 2;
    localparam int PER = 64 * P;

`ifdef RGB_PWM_ACTIVE_LOW_EN
    localparam logic OFF = 1'b1;
`else
    localparam logic OFF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] rgb;
    logic        en;
    logic        led_r, led_g, led_b, frame;

    int total = 0;
    int bad   = 0;

    // Reference model: k counts enabled edges since the run started (-1 while idle/reset).
    int         k;
    int         sr, sg, sb;
    logic       e_r, e_g, e_b, e_frame;

    rgb_pwm_driver #(.PRESCALE(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rgb   (rgb),
        .en    (en),
        .led_r (led_r),
        .led_g (led_g),
        .led_b (led_b),
        .frame (frame)
    );

    always #5 clk = ~clk;

    function automatic int exp5(input int v);
        return v * 2 + v / 16;
    endfunction

    task automatic model_reset();
        k = -1; sr = 0; sg = 0; sb = 0;
        e_r = OFF; e_g = OFF; e_b = OFF; e_frame = 1'b0;
    endtask

    task automatic model_edge();
        int r5, g6, b5, step;
        bit ld;
        r5 = (int'(rgb) / 2048) % 32;
        g6 = (int'(rgb) / 32) % 64;
        b5 = int'(rgb) % 32;
        if (!en) begin
            k = -1;
            e_r = OFF; e_g = OFF; e_b = OFF; e_frame = 1'b0;
            sr = exp5(r5); sg = g6; sb = exp5(b5);
        end else begin
            k    = k + 1;
            step = (k / P) % 64;
            ld   = (k % PER) == PER - 1;
            e_r  = OFF ^ (step < sr);
            e_g  = OFF ^ (step < sg);
            e_b  = OFF ^ (step < sb);
            e_frame = (k == 0) || ld;
            if (ld) begin
                sr = exp5(r5); sg = g6; sb = exp5(b5);
            end
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        total++;
        assert (obs == expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        chk("led_r", led_r, e_r);
        chk("led_g", led_g, e_g);
        chk("led_b", led_b, e_b);
        chk("frame", frame, e_frame);
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            tick_cycle();
            n++;
        end while (frame !== 1'b1 && n < 4 * PER);
        chk_int({tag, "_frame_seen"}, int'(frame === 1'b1), 1);
    endtask

    // Count on-cycles over the full period following a frame, and where the next frame lands.
    task automatic measure(input string tag, input int xr, input int xg, input int xb);
        int cr, cg, cb, fat;
        cr = 0; cg = 0; cb = 0; fat = -1;
        wait_frame(tag);
        for (int i = 1; i <= PER; i++) begin
            tick_cycle();
            if (led_r !== OFF) cr++;
            if (led_g !== OFF) cg++;
            if (led_b !== OFF) cb++;
            if (frame === 1'b1 && fat < 0) fat = i;
        end
        chk_int({tag, "_on_r"}, cr, xr);
        chk_int({tag, "_on_g"}, cg, xg);
        chk_int({tag, "_on_b"}, cb, xb);
        chk_int({tag, "_frame_period"}, fat, PER);
    endtask

    task automatic restart(input logic [15:0] colour);
        en = 1'b0; rgb = colour;
        tick_cycle();
        tick_cycle();
        en = 1'b1;
        tick_cycle();
        chk("start_frame", frame, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; rgb = 16'(($urandom));
        model_reset();
        #2;
        chk("reset_r", led_r, OFF);
        chk("reset_frame", frame, 1'b0);
        repeat (3) tick_cycle();
        rst_n = 1'b1;

        // Idle with random colours: outputs stay inactive.
        for (int i = 0; i < 6; i++) begin
            rgb = 16'($urandom);
            tick_cycle();
        end

        // Full scale.
        restart(16'hFFFF);
        measure("full", 126, 126, 126);

        // Asynchronous reset mid-run, observed before any clock edge.
        repeat (13) tick_cycle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_r", led_r, OFF);
        chk("async_g", led_g, OFF);
        chk("async_b", led_b, OFF);
        chk("async_frame", frame, 1'b0);
        repeat (2) tick_cycle();
        rst_n = 1'b1;
        tick_cycle();
        chk("post_reset_frame", frame, 1'b1);
        measure("post_reset", 126, 126, 126);

        // Zero and mixed colours.
        restart(16'h0000);
        measure("zero", 0, 0, 0);
        restart(16'h8410);
        measure("mixed", 66, 64, 66);

        // Mid-period update at step 20.
        restart(16'hF800);
        while (k < 20 * P) tick_cycle();
        rgb = 16'h001F;
        measure("midupd", 0, 0, 126);

        // Enable dropped at step 40, then raised.
        restart(16'h07E0);
        while (k < 40 * P) tick_cycle();
        en = 1'b0;
        tick_cycle();
        chk("drop_r", led_g, OFF);
        chk("drop_frame", frame, 1'b0);
        en = 1'b1;
        tick_cycle();
        chk("reen_frame", frame, 1'b1);
        measure("reen", 0, 126, 0);

        // Enable falls on the wrap edge: no frame.
        while (k != PER - 2 && k < 4 * PER) tick_cycle();
        en = 1'b0; rgb = 16'h1234;
        tick_cycle();
        chk("fall_wrap_frame", frame, 1'b0);

        // Random colours and occasional enable drops.
        for (int i = 0; i < 1500; i++) begin
            rgb = 16'($urandom);
            en  = ($urandom_range(0, 99) < 97);
            tick_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
